// File: rtl/spi_master_xfer.sv
// SPI master: one full-duplex DATA_W-bit exchange per start, all four CPOL/CPHA modes,
// MSB/LSB-first order and a runtime SCLK half-period divider.
module spi_master_xfer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_W);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  h_q, h_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
    logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DIV_W-1:0]  h_eff;
    logic              lead_edge;
    logic              sample_now;
    logic [BC_W-1:0]   bit_cnt_nxt;
    logic [DATA_W-1:0] rx_shifted;
    logic              tx_pop_bit;
    logic [DATA_W-1:0] tx_popped;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_d        = h_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        bit_cnt_d  = bit_cnt_q;
        shift_tx_d = shift_tx_q;
        shift_rx_d = shift_rx_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        h_eff = (cfg_div == '0) ? ONE : cfg_div;
        // sclk at its idle level means the next toggle is a leading edge
        lead_edge   = (sclk_q == cpol_q);
        sample_now  = lead_edge ^ cpha_q;
        bit_cnt_nxt = bit_cnt_q + BC_W'(sample_now);
        rx_shifted  = lsb_q ? {miso, shift_rx_q[DATA_W-1:1]}
                            : {shift_rx_q[DATA_W-2:0], miso};
        tx_pop_bit  = lsb_q ? shift_tx_q[0] : shift_tx_q[DATA_W-1];
        tx_popped   = lsb_q ? (shift_tx_q >> 1) : (shift_tx_q << 1);

        case (state_q)
            IDLE: begin
                sclk_d = cfg_cpol;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    h_d        = h_eff;
                    cpol_d     = cfg_cpol;
                    cpha_d     = cfg_cpha;
                    lsb_d      = cfg_lsb_first;
                    cnt_d      = h_eff - ONE;
                    bit_cnt_d  = '0;
                    shift_rx_d = '0;
                    shift_tx_d = tx_data;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = LEAD;
                    if (!cfg_cpha) begin
                        mosi_d     = cfg_lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                        shift_tx_d = cfg_lsb_first ? (tx_data >> 1) : (tx_data << 1);
                    end
                end
            end
            LEAD: begin
                if (cnt_q == '0) begin
                    cnt_d   = h_q - ONE;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            XFER: begin
                if (cnt_q == '0) begin
                    cnt_d  = h_q - ONE;
                    sclk_d = ~sclk_q;
                    if (sample_now) begin
                        shift_rx_d = rx_shifted;
                        bit_cnt_d  = bit_cnt_nxt;
                    end
                    if (lead_edge) begin
                        if (cpha_q) begin
                            mosi_d     = tx_pop_bit;
                            shift_tx_d = tx_popped;
                        end
                    end else if (bit_cnt_nxt == BC_LAST) begin
                        state_d = TRAIL;
                    end else if (!cpha_q) begin
                        mosi_d     = tx_pop_bit;
                        shift_tx_d = tx_popped;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            TRAIL: begin
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = shift_rx_q;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            h_q        <= ONE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            bit_cnt_q  <= '0;
            shift_tx_q <= '0;
            shift_rx_q <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_q        <= h_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_tx_q <= shift_tx_d;
            shift_rx_q <= shift_rx_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule
